// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared helpers for the pipelined add/subtract datapath.
//   sliceWidth        : bits handled by one pipeline stage (WIDTH/STAGES)
//   stagesDivideWidth : legality check for the WIDTH/STAGES pairing
//   signedOverflow    : two's-complement overflow from the three MSBs
// ---------------------------------------------------------------------------
package arith_pkg;

  // Width of one carry-chain slice. Guards against a zero stage count so a
  // bad parameter set reaches the legality check instead of dividing by zero.
  function automatic int sliceWidth(input int width, input int stages);
    if (stages >= 1) begin
      return width / stages;
    end
    return width;
  endfunction

  // A pairing is legal only when every stage gets the same whole number of bits.
  function automatic bit stagesDivideWidth(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

  // Overflow happens when both addends share a sign and the result does not.
  // bMsb must already be the possibly inverted B operand.
  function automatic logic signedOverflow(input logic aMsb,
                                          input logic bMsb,
                                          input logic sumMsb);
    return (aMsb == bMsb) && (sumMsb != aMsb);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Purely combinational W-bit ripple-carry adder used as one pipeline slice.
// Ports:
//   a, b  : W-bit addends (b is already inverted by the caller for subtract)
//   cin   : carry into bit 0
//   s     : W-bit sum
//   cout  : carry out of bit W-1
// ---------------------------------------------------------------------------
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] w_carry;

  // The whole ripple lives in one block so the carry vector is evaluated as
  // a single chain rather than as bits that look like they feed themselves.
  always_comb begin
    w_carry    = '0;
    s          = '0;
    w_carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]         = a[i] ^ b[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = w_carry[W];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// ---------------------------------------------------------------------------
// pipelined_adder_nbit
// WIDTH-bit add/subtract split into STAGES equal ripple slices, one slice per
// pipeline stage, carry registered between slices, valid/ready on both sides.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready is the global advance)
//   in_a, in_b          : WIDTH-bit operands
//   c_in                : carry-in for add, borrow-in for subtract
//   sub                 : 0 = add, 1 = subtract
//   out_valid/out_ready : output handshake
//   sum                 : WIDTH-bit result (registered)
//   c_out               : carry out of the MSB (subtract: 1 = no borrow)
//   ovf                 : two's-complement signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder_nbit
  import arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int W_S = sliceWidth(WIDTH, STAGES);

  // Unequal slices would break the skew/deskew bookkeeping, so refuse them.
  if (!stagesDivideWidth(WIDTH, STAGES)) begin : g_paramCheck
    $error("pipelined_adder_nbit: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // Per-stage inputs. Entry 0 comes straight from the ports, entry k+1 is
  // the register bank of stage k.
  logic              w_adv;
  logic [STAGES-1:0] w_validIn;
  logic [STAGES-1:0] w_carryIn;
  logic [STAGES-1:0] w_subIn;

  // The whole pipe moves as one shift register: it advances whenever the
  // output slot is empty or being drained. Bubbles are kept, not squeezed.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage 0 folds the borrow sense into the carry so every slice is a plain adder.
  assign w_validIn[0] = in_valid;
  assign w_carryIn[0] = c_in ^ sub;
  assign w_subIn[0]   = sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * W_S;
    localparam int SKEW = k;
    localparam int DSK  = STAGES - k;

    logic [W_S-1:0] w_a;
    logic [W_S-1:0] w_b;
    logic [W_S-1:0] w_bInv;
    logic [W_S-1:0] w_s;
    logic           w_cout;
    logic [W_S-1:0] r_dSkew [DSK];

    if (SKEW == 0) begin : g_noSkew
      assign w_a = in_a[LO +: W_S];
      assign w_b = in_b[LO +: W_S];
    end else begin : g_skew
      logic [W_S-1:0] r_aSkew [SKEW];
      logic [W_S-1:0] r_bSkew [SKEW];

      // Operand skew line: slice k waits k cycles so it meets the carry
      // that the lower slices of the same beat produce one stage at a time.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < SKEW; j++) begin
            r_aSkew[j] <= '0;
            r_bSkew[j] <= '0;
          end
        end else if (w_adv) begin
          r_aSkew[0] <= in_a[LO +: W_S];
          r_bSkew[0] <= in_b[LO +: W_S];
          for (int j = 1; j < SKEW; j++) begin
            r_aSkew[j] <= r_aSkew[j-1];
            r_bSkew[j] <= r_bSkew[j-1];
          end
        end
      end

      assign w_a = r_aSkew[SKEW-1];
      assign w_b = r_bSkew[SKEW-1];
    end

    // B is inverted here, with the sub flag that travelled with this beat,
    // rather than at the input, so the skew lines carry raw operands.
    assign w_bInv = w_b ^ {W_S{w_subIn[k]}};

    adder_slice #(
      .W(W_S)
    ) u_slice (
      .a   (w_a),
      .b   (w_bInv),
      .cin (w_carryIn[k]),
      .s   (w_s),
      .cout(w_cout)
    );

    // Result deskew line: entry 0 is this stage's sum register, and the low
    // slices sit here until the top slice of the same beat catches up.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < DSK; j++) begin
          r_dSkew[j] <= '0;
        end
      end else if (w_adv) begin
        r_dSkew[0] <= w_s;
        for (int j = 1; j < DSK; j++) begin
          r_dSkew[j] <= r_dSkew[j-1];
        end
      end
    end

    assign sum[LO +: W_S] = r_dSkew[DSK-1];

    if (k < STAGES - 1) begin : g_mid
      logic r_valid;
      logic r_carry;
      logic r_sub;

      // Intermediate stage bookkeeping: the beat's valid, its sub flag and
      // the carry out of this slice all move forward together.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_carry <= 1'b0;
          r_sub   <= 1'b0;
        end else if (w_adv) begin
          r_valid <= w_validIn[k];
          r_carry <= w_cout;
          r_sub   <= w_subIn[k];
        end
      end

      assign w_validIn[k+1] = r_valid;
      assign w_carryIn[k+1] = r_carry;
      assign w_subIn[k+1]   = r_sub;
    end else begin : g_last
      logic r_valid;
      logic r_carry;
      logic r_ovf;

      // The top slice holds both MSBs, so overflow is decided here and
      // registered alongside the final carry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_carry <= 1'b0;
          r_ovf   <= 1'b0;
        end else if (w_adv) begin
          r_valid <= w_validIn[k];
          r_carry <= w_cout;
          r_ovf   <= signedOverflow(w_a[W_S-1], w_bInv[W_S-1], w_s[W_S-1]);
        end
      end

      assign out_valid = r_valid;
      assign c_out     = r_carry;
      assign ovf       = r_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder_nbit
// Directed checks on a 16-bit / 4-stage unit plus exhaustive sweeps of the
// 4-bit / 1-stage and 4-bit / 2-stage configurations.
// ---------------------------------------------------------------------------
module tb_pipelined_adder_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 16-bit, 4-stage unit
  logic        inValid, inReady, cIn, subOp, outValid, outReady, cOut, ovf;
  logic [15:0] inA, inB, sum;

  // Shared stimulus for the two 4-bit units
  logic       sValid, sCin, sSub, sReady;
  logic [3:0] sA, sB;
  logic       s1InReady, s1Valid, s1Cout, s1Ovf;
  logic [3:0] s1Sum;
  logic       s2InReady, s2Valid, s2Cout, s2Ovf;
  logic [3:0] s2Sum;

  int checkCount = 0;
  int errorCount = 0;

  logic [5:0] q1 [$];
  logic [5:0] q2 [$];
  int got1 = 0;
  int got2 = 0;

  pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .in_a(inA), .in_b(inB), .c_in(cIn), .sub(subOp),
    .out_valid(outValid), .out_ready(outReady),
    .sum(sum), .c_out(cOut), .ovf(ovf)
  );

  pipelined_adder_nbit #(.WIDTH(4), .STAGES(1)) u_dutW4S1 (
    .clk(clk), .rst(rst),
    .in_valid(sValid), .in_ready(s1InReady),
    .in_a(sA), .in_b(sB), .c_in(sCin), .sub(sSub),
    .out_valid(s1Valid), .out_ready(sReady),
    .sum(s1Sum), .c_out(s1Cout), .ovf(s1Ovf)
  );

  pipelined_adder_nbit #(.WIDTH(4), .STAGES(2)) u_dutW4S2 (
    .clk(clk), .rst(rst),
    .in_valid(sValid), .in_ready(s2InReady),
    .in_a(sA), .in_b(sB), .c_in(sCin), .sub(sSub),
    .out_valid(s2Valid), .out_ready(sReady),
    .sum(s2Sum), .c_out(s2Cout), .ovf(s2Ovf)
  );

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference for the 4-bit units built from integer and signed arithmetic,
  // returns {c_out, ovf, sum}.
  function automatic logic [5:0] smallModel(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin, input logic sb);
    int ua, ub, sa, sbv, total, stotal;
    logic co, ov;
    logic [31:0] t;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sbv = $signed(b);
    if (!sb) begin
      total  = ua + ub + int'(cin);
      stotal = sa + sbv + int'(cin);
      co     = (total > 15);
    end else begin
      total  = ua - ub - int'(cin);
      stotal = sa - sbv - int'(cin);
      co     = (total >= 0);
    end
    ov = (stotal > 7) || (stotal < -8);
    t  = total;
    return {co, ov, t[3:0]};
  endfunction

  // One beat into the 16-bit unit; returns just after it is accepted.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sb);
    @(posedge clk);
    #1;
    inA     = a;
    inB     = b;
    cIn     = cin;
    subOp   = sb;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Single beat with latency and value check ({c_out, ovf, sum}).
  task automatic runSingle(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sb, input logic [17:0] expected);
    int n;
    applyStimulus(a, b, cin, sb);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!outValid && n < 10);
    checkOutput({tag, "_lat"}, n, 4);
    checkOutput(tag, {cOut, ovf, sum}, expected);
  endtask

  always @(negedge clk) begin
    if (s1Valid) begin
      if (q1.size() == 0) begin
        checkOutput("x41_extra", 1, 0);
      end else begin
        checkOutput("x41", {s1Cout, s1Ovf, s1Sum}, q1.pop_front());
        got1++;
      end
    end
    if (s2Valid) begin
      if (q2.size() == 0) begin
        checkOutput("x42_extra", 1, 0);
      end else begin
        checkOutput("x42", {s2Cout, s2Ovf, s2Sum}, q2.pop_front());
        got2++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [17:0] bpExp [8];
  int rdyPat [4];

  initial begin
    bpExp = '{ {2'b00, 16'h0F0F}, {2'b00, 16'h2020}, {2'b00, 16'h3131}, {2'b00, 16'h4242},
               {2'b00, 16'h5353}, {2'b00, 16'h6464}, {2'b00, 16'h7575}, {2'b01, 16'h8686} };
    rdyPat = '{1, 0, 0, 1};

    rst = 1'b1;
    inValid = 1'b0; inA = '0; inB = '0; cIn = 1'b0; subOp = 1'b0; outReady = 1'b1;
    sValid = 1'b0; sA = '0; sB = '0; sCin = 1'b0; sSub = 1'b0; sReady = 1'b1;

    #2;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_c_out", cOut, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_small_valid", {s1Valid, s2Valid}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_in_ready", inReady, 1);

    // Directed vectors, hand-computed {c_out, ovf, sum}
    runSingle("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    runSingle("ovf_add",      16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    runSingle("ovf_sub",      16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    runSingle("sub_borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    runSingle("sub_bin",      16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFD});
    runSingle("add_cin",      16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});

    // Backpressure: 8 back-to-back beats against a 1,0,0,1 ready pattern
    fork
      begin : producer
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < 8 && guard < 100) begin
          @(posedge clk);
          #1;
          inValid = 1'b1;
          inA     = 16'(i * 16'h1111);
          inB     = 16'h0F0F;
          cIn     = 1'b0;
          subOp   = 1'b0;
          @(negedge clk);
          guard++;
          if (inReady) i++;
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("bp_sent", i, 8);
      end
      begin : consumer
        int j;
        int cyc;
        j = 0;
        cyc = 0;
        while (j < 8 && cyc < 200) begin
          @(posedge clk);
          #1;
          outReady = (rdyPat[cyc % 4] != 0);
          cyc++;
          @(negedge clk);
          if (outValid) begin
            if (outReady) begin
              checkOutput("bp_data", {cOut, ovf, sum}, bpExp[j]);
              j++;
            end else begin
              checkOutput("bp_hold", {cOut, ovf, sum}, bpExp[j]);
              checkOutput("bp_in_ready", inReady, 0);
            end
          end
        end
        checkOutput("bp_count", j, 8);
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    repeat (6) begin
      @(negedge clk);
      checkOutput("bp_no_dup", outValid, 0);
    end

    // Reset mid-stream with a result sitting at the output
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      inValid = 1'b1;
      inA     = 16'(16'h0100 * (k + 1));
      inB     = 16'h0003;
      cIn     = 1'b0;
      subOp   = 1'b0;
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_pre_valid", outValid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", outValid, 0);
    checkOutput("rst_mid_sum", sum, 0);
    checkOutput("rst_mid_flags", {cOut, ovf}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_ready", inReady, 1);
    repeat (6) begin
      @(negedge clk);
      checkOutput("rst_no_stale", outValid, 0);
    end
    runSingle("rst_after", 16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002});

    // Exhaustive sweep of both 4-bit configurations
    for (int v = 0; v < 1024; v++) begin
      @(posedge clk);
      #1;
      {sSub, sCin, sA, sB} = 10'(v);
      sValid = 1'b1;
      q1.push_back(smallModel(sA, sB, sCin, sSub));
      q2.push_back(smallModel(sA, sB, sCin, sSub));
    end
    @(posedge clk);
    #1;
    sValid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("x41_count", got1, 1024);
    checkOutput("x42_count", got2, 1024);
    checkOutput("x_left", q1.size() + q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised, pipelined N-bit add/subtract unit with a valid/ready stream interface. The WIDTH-bit operation is split into STAGES equal carry-chain slices, one slice per pipeline stage, with the carry registered between slices. It sustains one operation per cycle at a clock rate set by a WIDTH/STAGES-bit ripple chain. It is the general arithmetic building block for datapaths that need wider operands than a single-cycle ripple adder can close timing on.

## Interface

Parameters:
- WIDTH, 16, operand and result width in bits; must be at least 1.
- STAGES, 4, number of pipeline stages and carry slices; WIDTH % STAGES == 0 is required; STAGES >= 1.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- c_in  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry-out of the MSB (for subtract, 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

## Operation

- Result definition: {c_out, sum} = in_a + (in_b XOR {WIDTH{sub}}) + (c_in XOR sub), evaluated at full WIDTH+1 bits.
  - sub=1, c_in=0 gives A−B.
  - sub=1, c_in=1 gives A−B−1 (borrow-in).
- ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted B.
- Slice width is W_S = WIDTH/STAGES. Stage k (k = 0..STAGES−1) adds bits [k·W_S +: W_S] using the carry registered by stage k−1. Stage 0 uses c_in XOR sub.
- Operand skew: the bits for slice k are delayed k cycles before entering stage k.
- Result deskew: the completed low slices are delayed so that all slices of one beat reach the output in the same cycle.
- Each stage carries a valid bit. The beat's sub flag travels alongside the operands.
- Flow control uses a single global advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, every stage register shifts one position and stage 0 loads {in_valid, operands}.
  - When adv=0, all registers hold.
- Bubbles are not compressed: an empty stage propagates as an invalid slot.
- A beat transfers on input when in_valid && in_ready, and on output when out_valid && out_ready.

## Timing

- Latency: a beat accepted at edge t appears on out_valid/sum/c_out/ovf after edge t+STAGES−1 (STAGES registered stages) when never stalled.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, sum/c_out/ovf stay stable and in_ready=0. The upstream holds its beat.
- Output stability: sum/c_out/ovf are registered outputs. Their value is meaningful only when out_valid=1, and they are not required to hold their value after a transfer.
- Reset (asynchronous, at any time including mid-stream): all stage valid bits = 0, out_valid = 0, sum = 0, c_out = 0, ovf = 0, internal carries = 0. In-flight beats are discarded. in_ready = 1 in the first cycle after reset release.
- STAGES=1: a single registered full-width adder with latency 1.
- STAGES=WIDTH: a 1-bit slice per stage.
- Wrap-around: results are modulo 2^WIDTH, and carry/borrow is reported only through c_out.

## Structure

- Shared package (arith_pkg): slice-width function, the WIDTH % STAGES check, and the ovf computation function.
- Sub-module adder_slice: a combinational W_S-bit ripple-carry adder with ports (a, b, cin, s, cout). It is instantiated STAGES times by a generate loop.
- Skew and deskew delay lines are inline generate loops of registers.
- An elaboration-time assertion rejects a WIDTH that is not divisible by STAGES.

## Test plan

All scenarios use WIDTH=16, STAGES=4 unless noted.

- Carry ripple across all slices: A=0xFFFF, B=0x0001, c_in=0, sub=0 -> after 4 cycles sum=0x0000, c_out=1, ovf=0.
- Signed overflow: A=0x7FFF, B=0x0001, add -> sum=0x8000, c_out=0, ovf=1. A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1.
- Subtract with borrow:
  - A=0x0005, B=0x0007, sub=1, c_in=0 -> sum=0xFFFE, c_out=0, ovf=0.
  - Same operands with c_in=1 -> sum=0xFFFD.
- Backpressure: stream 8 back-to-back beats (A=i·0x1111, B=0x0F0F) while out_ready toggles 1,0,0,1,... -> all 8 results appear in order with no loss or duplication, and sum holds while out_ready=0.
- Reset mid-stream: accept 3 beats, assert rst for 1 cycle -> out_valid=0 immediately, no stale result ever emerges, and a new beat 0x0001+0x0001 yields 0x0002 after 4 cycles.
- Exhaustive small configuration: WIDTH=4, STAGES=1 and WIDTH=4, STAGES=2, all 2^10 combinations of (A, B, c_in, sub) -> every result matches the reference model.
